// File: rtl/fold_karatsuba_mult.sv
// Pipelined WxW->2W multiplier with one Karatsuba fold (three half-width products)
// against a runtime-reloadable coefficient Y. Define KMUL_STALL_EN for out_ready back-pressure.
module fold_karatsuba_mult #(
  parameter int          W           = 128,
  parameter int          MULT_STAGES = 3,
  parameter logic [W-1:0] Y_INIT     = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   X,
  input  logic           y_load,
  input  logic [W-1:0]   Y_in,
  output logic           y_busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] P
);
  localparam int H   = W / 2;
  localparam int LAT = MULT_STAGES + 3;
  localparam int OW  = $clog2(LAT + 1);
  localparam logic [H:0] YS_INIT = {1'b0, Y_INIT[H-1:0]} + {1'b0, Y_INIT[W-1:H]};

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PRECOMP} state_t;
  state_t state_reg, state_next;

  logic [W-1:0]  y_reg, shadow_reg;
  logic [H:0]    ys_reg;
  logic [OW-1:0] occ_reg, occ_next;
  logic          stall, advance, accept, y_accept, out_fire;

  logic [H-1:0]  x0_reg, x1_reg;
  logic [H:0]    xs_reg;
  logic          s0_valid_reg;

  logic [W-1:0]  a_prod, b_prod;
  logic [W+1:0]  c_prod;

  logic [W-1:0]  a_last, b_last;
  logic [W+1:0]  c_last;
  logic          mult_valid_last;

  logic [W+1:0]  m_wide;
  logic          unused_m_msb;
  logic [W-1:0]  a_mid_reg, b_mid_reg;
  logic [W:0]    m_reg;
  logic          mid_valid_reg;

  logic [W:0]    lo_reg;
  logic [W-1:0]  hi_reg;
  logic          f1_valid_reg;

  logic [2*W-1:0] p_reg;
  logic           out_valid_reg;

`ifdef KMUL_STALL_EN
  assign stall    = out_valid_reg && !out_ready;
  assign out_fire = out_valid_reg && out_ready;
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign stall    = 1'b0;
  assign out_fire = out_valid_reg;
`endif

  assign advance = !stall;
  assign accept  = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    y_busy     = 1'b0;
    y_accept   = 1'b0;
    case (state_reg)
      ST_RUN: begin
        in_ready = !reset && !stall;
        y_accept = y_load && !reset;
        if (y_accept) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        y_busy = 1'b1;
        if (occ_reg == '0) state_next = ST_PRECOMP;
      end
      ST_PRECOMP: begin
        y_busy     = 1'b1;
        state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    occ_next = occ_reg;
    if (accept && !out_fire)      occ_next = occ_reg + OW'(1);
    else if (!accept && out_fire) occ_next = occ_reg - OW'(1);
  end

  // Y only changes in PRECOMP, which is reached with an empty pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ST_RUN;
      occ_reg    <= '0;
      shadow_reg <= '0;
      y_reg      <= Y_INIT;
      ys_reg     <= YS_INIT;
    end else begin
      state_reg <= state_next;
      occ_reg   <= occ_next;
      if (y_accept) shadow_reg <= Y_in;
      if (state_reg == ST_PRECOMP) begin
        y_reg  <= shadow_reg;
        ys_reg <= {1'b0, shadow_reg[H-1:0]} + {1'b0, shadow_reg[W-1:H]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x0_reg       <= '0;
      x1_reg       <= '0;
      xs_reg       <= '0;
      s0_valid_reg <= 1'b0;
    end else if (advance) begin
      x0_reg       <= X[H-1:0];
      x1_reg       <= X[W-1:H];
      xs_reg       <= {1'b0, X[H-1:0]} + {1'b0, X[W-1:H]};
      s0_valid_reg <= accept;
    end
  end

  assign a_prod = {{H{1'b0}}, x0_reg} * {{H{1'b0}}, y_reg[H-1:0]};
  assign b_prod = {{H{1'b0}}, x1_reg} * {{H{1'b0}}, y_reg[W-1:H]};
  assign c_prod = {{(H+1){1'b0}}, xs_reg} * {{(H+1){1'b0}}, ys_reg};

  for (genvar gi = 0; gi < MULT_STAGES; gi++) begin : g_mult
    logic [W-1:0] a_reg, b_reg, a_in, b_in;
    logic [W+1:0] c_reg, c_in;
    logic         valid_reg, valid_in;

    if (gi == 0) begin : g_src
      assign a_in     = a_prod;
      assign b_in     = b_prod;
      assign c_in     = c_prod;
      assign valid_in = s0_valid_reg;
    end else begin : g_src
      assign a_in     = g_mult[gi-1].a_reg;
      assign b_in     = g_mult[gi-1].b_reg;
      assign c_in     = g_mult[gi-1].c_reg;
      assign valid_in = g_mult[gi-1].valid_reg;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        a_reg     <= '0;
        b_reg     <= '0;
        c_reg     <= '0;
        valid_reg <= 1'b0;
      end else if (advance) begin
        a_reg     <= a_in;
        b_reg     <= b_in;
        c_reg     <= c_in;
        valid_reg <= valid_in;
      end
    end
  end

  assign a_last          = g_mult[MULT_STAGES-1].a_reg;
  assign b_last          = g_mult[MULT_STAGES-1].b_reg;
  assign c_last          = g_mult[MULT_STAGES-1].c_reg;
  assign mult_valid_last = g_mult[MULT_STAGES-1].valid_reg;

  // C - A - B is the cross term X0*Y1 + X1*Y0, which always fits in W+1 bits.
  assign m_wide       = c_last - {2'b00, a_last} - {2'b00, b_last};
  assign unused_m_msb = m_wide[W+1];

  always_ff @(posedge clock) begin
    if (reset) begin
      a_mid_reg     <= '0;
      b_mid_reg     <= '0;
      m_reg         <= '0;
      mid_valid_reg <= 1'b0;
    end else if (advance) begin
      a_mid_reg     <= a_last;
      b_mid_reg     <= b_last;
      m_reg         <= m_wide[W:0];
      mid_valid_reg <= mult_valid_last;
    end
  end

  // The 2W recombination is split into a low half with carry-out and a high half.
  always_ff @(posedge clock) begin
    if (reset) begin
      lo_reg       <= '0;
      hi_reg       <= '0;
      f1_valid_reg <= 1'b0;
    end else if (advance) begin
      lo_reg       <= {1'b0, a_mid_reg} + {1'b0, m_reg[H-1:0], {H{1'b0}}};
      hi_reg       <= b_mid_reg + {{(H-1){1'b0}}, m_reg[W:H]};
      f1_valid_reg <= mid_valid_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else if (advance) begin
      p_reg         <= {hi_reg + {{(W-1){1'b0}}, lo_reg[W]}, lo_reg[W-1:0]};
      out_valid_reg <= f1_valid_reg;
    end
  end

  assign P         = p_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_fold_karatsuba_mult.sv
// Self-checking bench for fold_karatsuba_mult: a W=16 instance for directed and random
// checks and a W=128 instance checked against 256-bit golden products.
module tb_fold_karatsuba_mult;
  localparam int            LAT  = 6;
  localparam logic [15:0]   YI   = 16'h1234;
  localparam int            LATW = 7;
  localparam logic [127:0]  YIW  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  typedef struct { logic [31:0] p; int due; } exp16_t;
  typedef struct { logic [255:0] p; int due; } expw_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] y16_model = YI;

  logic        in_valid = 1'b0, in_ready, y_load = 1'b0, y_busy, out_valid, out_ready = 1'b1;
  logic [15:0] x = '0, y_in = '0;
  logic [31:0] p;

  logic         w_in_valid = 1'b0, w_in_ready, w_y_load = 1'b0, w_y_busy, w_out_valid, w_out_ready = 1'b1;
  logic [127:0] w_x = '0, w_y_in = '0;
  logic [255:0] w_p;

  fold_karatsuba_mult #(.W(16), .MULT_STAGES(3), .Y_INIT(YI)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .X(x),
    .y_load(y_load), .Y_in(y_in), .y_busy(y_busy), .out_valid(out_valid),
    .out_ready(out_ready), .P(p));

  fold_karatsuba_mult #(.W(128), .MULT_STAGES(4), .Y_INIT(YIW)) dut_w (
    .clock(clock), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready), .X(w_x),
    .y_load(w_y_load), .Y_in(w_y_in), .y_busy(w_y_busy), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .P(w_p));

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one X, then watches the output for a window; returns what it saw.
  task automatic send_one(input logic [15:0] xv, output logic rdy, output int k,
                          output int hits, output int hit_cyc, output logic [31:0] hit_p);
    @(negedge clock);
    in_valid = 1'b1;
    x = xv;
    #1 rdy = in_ready;
    @(posedge clock);
    #1 k = cyc;
    in_valid = 1'b0;
    hits = 0; hit_cyc = -1; hit_p = '0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clock);
      if (out_valid) begin
        hits++; hit_cyc = cyc; hit_p = p;
        $display("txn16 x=%h P=%h cycle=%0d", xv, p, cyc);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    compared++; if (p !== 32'h0) begin mismatched++; $display("FAIL reset_p: got %h want 0", p); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    compared++; if (y_busy !== 1'b0) begin mismatched++; $display("FAIL reset_y_busy: got %b want 0", y_busy); end
    reset = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    compared++; if (w_in_ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_w_in_ready: got %b want 1", w_in_ready); end
  endtask

  task automatic test_single();
    logic rdy; int k, hits, hc; logic [31:0] hp;
    send_one(16'hFFFF, rdy, k, hits, hc, hp);
    compared++; if (rdy !== 1'b1) begin mismatched++; $display("FAIL single_ready: got %b want 1", rdy); end
    compared++; if (hits != 1) begin mismatched++; $display("FAIL single_pulses: got %0d want 1", hits); end
    compared++; if (hc != k + LAT) begin mismatched++; $display("FAIL single_latency: got cycle %0d want %0d", hc, k + LAT); end
    compared++; if (hp !== 32'h1233EDCC) begin mismatched++; $display("FAIL single_p: got %h want 1233edcc", hp); end
  endtask

  task automatic test_reload();
    int k, ready_cyc, hits, hc, k2, hc2; logic [31:0] hp, hp2; logic rdy, busy_mid;
    @(negedge clock);
    in_valid = 1'b1; x = 16'd5; y_load = 1'b1; y_in = 16'h0002;
    #1 rdy = in_ready;
    @(posedge clock);
    #1 k = cyc;
    in_valid = 1'b0; y_load = 1'b0;
    ready_cyc = -1; hits = 0; hc = -1; hp = '0; busy_mid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (out_valid) begin
        hits++; hc = cyc; hp = p;
        $display("txn16 x=0005 P=%h cycle=%0d", p, cyc);
      end
      if (cyc == k + 2) busy_mid = y_busy;
      if (in_ready && ready_cyc < 0) ready_cyc = cyc;
    end
    compared++; if (rdy !== 1'b1) begin mismatched++; $display("FAIL reload_accept: got %b want 1", rdy); end
    compared++; if (hits != 1 || hp !== 32'h00005B04) begin mismatched++; $display("FAIL reload_old_y: got %0d results P=%h want 1 result P=00005b04", hits, hp); end
    compared++; if (hc != k + LAT) begin mismatched++; $display("FAIL reload_old_latency: got %0d want %0d", hc, k + LAT); end
    compared++; if (busy_mid !== 1'b1) begin mismatched++; $display("FAIL reload_busy: got %b want 1", busy_mid); end
    compared++; if (ready_cyc != k + LAT + 3) begin mismatched++; $display("FAIL reload_ready_back: got cycle %0d want %0d", ready_cyc, k + LAT + 3); end
    y16_model = 16'h0002;
    send_one(16'd5, rdy, k2, hits, hc2, hp2);
    compared++; if (hits != 1 || hp2 !== 32'h0000000A) begin mismatched++; $display("FAIL reload_new_y: got %0d results P=%h want 1 result P=0000000a", hits, hp2); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs [4];
    logic [31:0] want [4];
    logic [31:0] got_p [$];
    int got_c [$];
    int k, k0; logic r0, r1, r2, rdy_all;
    xs = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF};
    want = '{32'h0000FFFF, 32'h0001FFFE, 32'h0002FFFD, 32'hFFFE0001};
    // empty-pipeline reload to 0xFFFF: RUN again two edges after the request
    @(negedge clock);
    y_load = 1'b1; y_in = 16'hFFFF;
    @(posedge clock);
    #1 k = cyc;
    y_load = 1'b0;
    @(negedge clock); r0 = in_ready;
    @(negedge clock); r1 = in_ready;
    @(negedge clock); r2 = in_ready;
    compared++; if ({r0, r1, r2} !== 3'b001) begin mismatched++; $display("FAIL reload_empty_ready: got %b%b%b want 001 (edges %0d..%0d)", r0, r1, r2, k, k + 2); end
    y16_model = 16'hFFFF;
    rdy_all = 1'b1;
    k0 = cyc + 1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clock);
      in_valid = 1'b1; x = xs[j];
      #1 rdy_all = rdy_all & in_ready;
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      in_valid = 1'b0;
      if (out_valid) begin
        got_p.push_back(p); got_c.push_back(cyc);
        $display("txn16 P=%h cycle=%0d", p, cyc);
      end
    end
    compared++; if (rdy_all !== 1'b1) begin mismatched++; $display("FAIL b2b_ready: got %b want 1", rdy_all); end
    compared++; if (got_p.size() != 4) begin mismatched++; $display("FAIL b2b_count: got %0d want 4", got_p.size()); end
    for (int j = 0; j < 4 && j < got_p.size(); j++) begin
      compared++;
      if (got_p[j] !== want[j] || got_c[j] != k0 + LAT + j) begin
        mismatched++;
        $display("FAIL b2b_result%0d: got P=%h at %0d want P=%h at %0d", j, got_p[j], got_c[j], want[j], k0 + LAT + j);
      end
    end
  endtask

  task automatic test_reset_in_drain();
    int k, hits, hc; logic [31:0] hp; logic rdy;
    @(negedge clock);
    in_valid = 1'b1; x = 16'd3; y_load = 1'b1; y_in = 16'h0007;
    @(negedge clock);
    in_valid = 1'b0; y_load = 1'b0;
    compared++; if (y_busy !== 1'b1) begin mismatched++; $display("FAIL drain_entered: got y_busy=%b want 1", y_busy); end
    reset = 1'b1;
    @(negedge clock);
    compared++; if (y_busy !== 1'b0) begin mismatched++; $display("FAIL drain_reset_busy: got %b want 0", y_busy); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL drain_reset_out_valid: got %b want 0", out_valid); end
    reset = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL drain_reset_ready: got %b want 1", in_ready); end
    y16_model = YI;
    send_one(16'd1, rdy, k, hits, hc, hp);
    compared++; if (hits != 1 || hp !== 32'h00001234) begin mismatched++; $display("FAIL drain_reset_y_init: got %0d results P=%h want 1 result P=00001234", hits, hp); end
  endtask

  task automatic test_random_narrow();
    exp16_t q [$];
    exp16_t e;
    logic [31:0] prod;
    logic late;
    for (int i = 0; i < 320; i++) begin
      @(negedge clock);
`ifdef KMUL_STALL_EN
      out_ready = (i >= 300) ? 1'b1 : ($urandom_range(0, 2) != 0);
`else
      out_ready = $urandom_range(0, 1);
`endif
      if (out_valid && (out_ready || `ifdef KMUL_STALL_EN 1'b0 `else 1'b1 `endif)) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++; $display("FAIL rnd16_extra: got P=%h want no result", p);
        end else begin
          e = q.pop_front();
          late = 1'b0;
`ifndef KMUL_STALL_EN
          late = (cyc != e.due);
`endif
          $display("txn16 P=%h cycle=%0d", p, cyc);
          if (p !== e.p || late) begin
            mismatched++; $display("FAIL rnd16_result: got P=%h at %0d want P=%h at %0d", p, cyc, e.p, e.due);
          end
        end
      end
      in_valid = (i < 300) && ($urandom_range(0, 3) != 0);
      x = 16'($urandom);
      y_load = (i < 300) && ($urandom_range(0, 39) == 0);
      y_in = 16'($urandom);
      #1;
      if (in_valid && in_ready) begin
        prod = 32'(x) * 32'(y16_model);
        q.push_back('{prod, cyc + 1 + LAT});
      end
      if (y_load && !y_busy) y16_model = y_in;
    end
    in_valid = 1'b0; y_load = 1'b0; out_ready = 1'b1;
    compared++; if (q.size() != 0) begin mismatched++; $display("FAIL rnd16_lost: got %0d outstanding want 0", q.size()); end
  endtask

  task automatic test_out_ready();
    logic [31:0] e [3];
    logic [15:0] xv;
    logic rdy_all;
    int k0;
    logic [31:0] got_p [$];
    int got_c [$];
    rdy_all = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    k0 = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clock);
      xv = 16'($urandom);
      e[j] = 32'(xv) * 32'(y16_model);
      in_valid = 1'b1; x = xv;
      #1 rdy_all = rdy_all & in_ready;
    end
    @(negedge clock);
    in_valid = 1'b0;
    compared++; if (rdy_all !== 1'b1) begin mismatched++; $display("FAIL outrdy_accept: got %b want 1", rdy_all); end
`ifdef KMUL_STALL_EN
    begin
      int waited;
      waited = 0;
      while (!out_valid && waited < 12) begin @(negedge clock); waited++; end
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL stall_timeout: got out_valid=%b want 1", out_valid); end
      for (int h = 0; h < 4; h++) begin
        if (h > 0) @(negedge clock);
        compared++;
        if (out_valid !== 1'b1 || p !== e[0] || in_ready !== 1'b0) begin
          mismatched++; $display("FAIL stall_hold%0d: got v=%b P=%h rdy=%b want v=1 P=%h rdy=0", h, out_valid, p, in_ready, e[0]);
        end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clock);
        if (out_valid) begin got_p.push_back(p); $display("txn16 P=%h cycle=%0d", p, cyc); end
      end
      compared++;
      if (got_p.size() != 2) begin
        mismatched++; $display("FAIL stall_count: got %0d want 2", got_p.size());
      end else if (got_p[0] !== e[1] || got_p[1] !== e[2]) begin
        mismatched++; $display("FAIL stall_order: got %h %h want %h %h", got_p[0], got_p[1], e[1], e[2]);
      end
    end
`else
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin got_p.push_back(p); got_c.push_back(cyc); $display("txn16 P=%h cycle=%0d", p, cyc); end
      @(negedge clock);
    end
    compared++; if (got_p.size() != 3) begin mismatched++; $display("FAIL noready_count: got %0d want 3", got_p.size()); end
    for (int j = 0; j < 3 && j < got_p.size(); j++) begin
      compared++;
      if (got_p[j] !== e[j] || got_c[j] != k0 + LAT + j) begin
        mismatched++; $display("FAIL noready_result%0d: got P=%h at %0d want P=%h at %0d", j, got_p[j], got_c[j], e[j], k0 + LAT + j);
      end
    end
`endif
    out_ready = 1'b1;
  endtask

  task automatic test_random_wide();
    expw_t q [$];
    expw_t e;
    logic [127:0] cur_y;
    logic [255:0] prod;
    cur_y = YIW;
    for (int i = 0; i < 240; i++) begin
      @(negedge clock);
      if (w_out_valid) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++; $display("FAIL rnd128_extra: got P=%h want no result", w_p);
        end else begin
          e = q.pop_front();
          $display("txn128 P=%h cycle=%0d", w_p, cyc);
          if (w_p !== e.p || cyc != e.due) begin
            mismatched++; $display("FAIL rnd128_result: got P=%h at %0d want P=%h at %0d", w_p, cyc, e.p, e.due);
          end
        end
      end
      w_in_valid = (i < 220) && ($urandom_range(0, 3) != 0);
      w_x = (i % 37 == 3) ? {128{1'b1}} : rand128();
      w_y_load = (i < 220) && ((i == 60) || ($urandom_range(0, 29) == 0));
      w_y_in = (i == 60) ? {128{1'b1}} : rand128();
      #1;
      if (w_in_valid && w_in_ready) begin
        prod = 256'(w_x) * 256'(cur_y);
        q.push_back('{prod, cyc + 1 + LATW});
      end
      if (w_y_load && !w_y_busy) cur_y = w_y_in;
    end
    w_in_valid = 1'b0; w_y_load = 1'b0;
    compared++; if (q.size() != 0) begin mismatched++; $display("FAIL rnd128_lost: got %0d outstanding want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reload();
    test_back_to_back();
    test_reset_in_drain();
    test_random_narrow();
    test_out_ready();
    test_random_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
